// File: rtl/ysyx_22050598_hazard_ctrl_if.sv
// Bundle of hazard-detection inputs and pipeline stall/flush/redirect controls
// exchanged between the pipeline datapath (master) and the hazard unit (slave).
interface ysyx_22050598_hazard_ctrl_if #(
    parameter int XLEN = 64
);
    logic [4:0]      id_rs1_idx;
    logic            id_rs1_used;
    logic [4:0]      id_rs2_idx;
    logic            id_rs2_used;
    logic [4:0]      ex_rd_idx;
    logic            ex_w_reg_en;
    logic            ex_is_load;
    logic            ex_mdu_start;
    logic            ex_mdu_is_div;
    logic            ex_redirect;
    logic [XLEN-1:0] ex_redirect_pc;
    logic            trap_redirect;
    logic [XLEN-1:0] trap_pc;
    logic            lsu_busy;

    logic            pc_stall;
    logic            if_id_stall;
    logic            id_ex_stall;
    logic            ex_mem_stall;
    logic            if_id_flush;
    logic            id_ex_flush;
    logic            ex_mem_flush;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_redirect_target;
    logic            mdu_busy;
    logic            mdu_done;

    modport master (
        output id_rs1_idx, id_rs1_used, id_rs2_idx, id_rs2_used,
               ex_rd_idx, ex_w_reg_en, ex_is_load, ex_mdu_start, ex_mdu_is_div,
               ex_redirect, ex_redirect_pc, trap_redirect, trap_pc, lsu_busy,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, ex_mem_flush,
               pc_redirect, pc_redirect_target, mdu_busy, mdu_done
    );

    modport slave (
        input  id_rs1_idx, id_rs1_used, id_rs2_idx, id_rs2_used,
               ex_rd_idx, ex_w_reg_en, ex_is_load, ex_mdu_start, ex_mdu_is_div,
               ex_redirect, ex_redirect_pc, trap_redirect, trap_pc, lsu_busy,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, ex_mem_flush,
               pc_redirect, pc_redirect_target, mdu_busy, mdu_done
    );
endinterface

// File: rtl/ysyx_22050598_hazard_ctrl.sv
// Pipeline hazard unit: load-use bubbles, multi-cycle MUL/DIV occupancy of EX,
// LSU freeze, and branch/trap redirects held pending until the pipe unfreezes.
module ysyx_22050598_hazard_ctrl #(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_22050598_hazard_ctrl_if.slave   hz
);
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_BUSY,
        MDU_DONE
    } mdu_state_t;

    mdu_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic            pend, pend_nxt;
    logic [XLEN-1:0] pend_pc, pend_pc_nxt;

    logic            freeze;
    logic            load_use;
    logic            redir_req;
    logic [XLEN-1:0] redir_new;

    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic if_id_flush, id_ex_flush, ex_mem_flush;
    logic pc_redirect, mdu_busy, mdu_done;
    logic [XLEN-1:0] redirect_target;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= MDU_IDLE;
            cnt     <= '0;
            pend    <= 1'b0;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend    <= pend_nxt;
            pend_pc <= pend_pc_nxt;
        end
    end

    assign freeze    = hz.lsu_busy | (state == MDU_BUSY);
    assign redir_req = hz.trap_redirect | hz.ex_redirect;
    assign redir_new = hz.trap_redirect ? hz.trap_pc : hz.ex_redirect_pc;
    assign load_use  = hz.ex_is_load & hz.ex_w_reg_en & (hz.ex_rd_idx != 5'd0) &
                       ((hz.id_rs1_used & (hz.id_rs1_idx == hz.ex_rd_idx)) |
                        (hz.id_rs2_used & (hz.id_rs2_idx == hz.ex_rd_idx)));

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        pend_nxt        = pend;
        pend_pc_nxt     = pend_pc;
        pc_stall        = 1'b0;
        if_id_stall     = 1'b0;
        id_ex_stall     = 1'b0;
        ex_mem_stall    = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_flush    = 1'b0;
        pc_redirect     = 1'b0;
        redirect_target = '0;
        mdu_busy        = 1'b0;
        mdu_done        = 1'b0;

        // The counter only advances while memory is idle, so an LSU stall stretches MDU occupancy.
        case (state)
            MDU_IDLE: begin
                if (hz.ex_mdu_start && !hz.lsu_busy) begin
                    state_nxt = MDU_BUSY;
                    cnt_nxt   = hz.ex_mdu_is_div ? DIV_INIT : MUL_INIT;
                end
            end
            MDU_BUSY: begin
                if (!hz.lsu_busy) begin
                    if (cnt == '0) state_nxt = MDU_DONE;
                    else           cnt_nxt   = cnt - 1'b1;
                end
            end
            MDU_DONE: state_nxt = MDU_IDLE;
            default:  state_nxt = MDU_IDLE;
        endcase

        // A trap always replaces the held target; a branch only fills an empty slot.
        if (freeze) begin
            if (hz.trap_redirect) begin
                pend_nxt    = 1'b1;
                pend_pc_nxt = hz.trap_pc;
            end else if (hz.ex_redirect && !pend) begin
                pend_nxt    = 1'b1;
                pend_pc_nxt = hz.ex_redirect_pc;
            end
        end else begin
            pend_nxt = 1'b0;
        end

        if (rst) begin
            mdu_busy = (state == MDU_BUSY);
            mdu_done = (state == MDU_DONE);
            if (hz.lsu_busy) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
            end else if (state == MDU_BUSY) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (redir_req || pend) begin
                pc_redirect     = 1'b1;
                redirect_target = pend ? pend_pc : redir_new;
                if_id_flush     = 1'b1;
                id_ex_flush     = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign hz.pc_stall           = pc_stall;
    assign hz.if_id_stall        = if_id_stall;
    assign hz.id_ex_stall        = id_ex_stall;
    assign hz.ex_mem_stall       = ex_mem_stall;
    assign hz.if_id_flush        = if_id_flush;
    assign hz.id_ex_flush        = id_ex_flush;
    assign hz.ex_mem_flush       = ex_mem_flush;
    assign hz.pc_redirect        = pc_redirect;
    assign hz.pc_redirect_target = redirect_target;
    assign hz.mdu_busy           = mdu_busy;
    assign hz.mdu_done           = mdu_done;
endmodule

// File: tb/tb_ysyx_22050598_hazard_ctrl.sv
// Directed self-checking bench for the hazard unit; each task exercises one
// scenario against hand-derived control vectors.
module tb_ysyx_22050598_hazard_ctrl;
    // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush,
    //  ex_mem_flush, pc_redirect, mdu_busy, mdu_done}
    localparam logic [9:0] C_NONE  = 10'b0000000000;
    localparam logic [9:0] C_LU    = 10'b1100010000;
    localparam logic [9:0] C_BUSY  = 10'b1110001010;
    localparam logic [9:0] C_DONE  = 10'b0000000001;
    localparam logic [9:0] C_LSU   = 10'b1111000000;
    localparam logic [9:0] C_REDIR = 10'b0000110100;
    localparam logic [9:0] C_DONE_REDIR = 10'b0000110101;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ysyx_22050598_hazard_ctrl_if #(.XLEN(64)) bus ();

    ysyx_22050598_hazard_ctrl #(
        .XLEN(64), .MUL_LAT(3), .DIV_LAT(33), .CNT_W(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    logic [9:0] ctl;
    assign ctl = {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall,
                  bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush,
                  bus.pc_redirect, bus.mdu_busy, bus.mdu_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.id_rs1_idx     = 5'd0;
        bus.id_rs1_used    = 1'b0;
        bus.id_rs2_idx     = 5'd0;
        bus.id_rs2_used    = 1'b0;
        bus.ex_rd_idx      = 5'd0;
        bus.ex_w_reg_en    = 1'b0;
        bus.ex_is_load     = 1'b0;
        bus.ex_mdu_start   = 1'b0;
        bus.ex_mdu_is_div  = 1'b0;
        bus.ex_redirect    = 1'b0;
        bus.ex_redirect_pc = 64'd0;
        bus.trap_redirect  = 1'b0;
        bus.trap_pc        = 64'd0;
        bus.lsu_busy       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        bus.lsu_busy    = 1'b1;
        bus.ex_is_load  = 1'b1;
        bus.ex_w_reg_en = 1'b1;
        bus.ex_rd_idx   = 5'd5;
        bus.id_rs1_idx  = 5'd5;
        bus.id_rs1_used = 1'b1;
        bus.ex_redirect = 1'b1;
        bus.ex_redirect_pc = 64'h8000_0100;
        tick();
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("[TB] FAIL reset_ctl got=%b exp=%b", ctl, C_NONE);
        end
        total++;
        if (bus.pc_redirect_target !== 64'd0) begin
            bad++;
            $display("[TB] FAIL reset_target got=%h exp=0", bus.pc_redirect_target);
        end
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        // A redirect latched during reset must not survive it.
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("[TB] FAIL after_reset_idle got=%b exp=%b", ctl, C_NONE);
        end
    endtask

    task automatic test_load_use();
        bus.ex_is_load  = 1'b1;
        bus.ex_w_reg_en = 1'b1;
        bus.ex_rd_idx   = 5'd5;
        bus.id_rs1_idx  = 5'd5;
        bus.id_rs1_used = 1'b1;
        #1;
        total++;
        if (ctl !== C_LU) begin
            bad++;
            $display("[TB] FAIL load_use_rs1 got=%b exp=%b", ctl, C_LU);
        end
        bus.ex_rd_idx  = 5'd0;
        bus.id_rs1_idx = 5'd0;
        #1;
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("[TB] FAIL load_use_x0 got=%b exp=%b", ctl, C_NONE);
        end
        bus.ex_rd_idx   = 5'd9;
        bus.id_rs1_idx  = 5'd9;
        bus.id_rs1_used = 1'b0;
        #1;
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("[TB] FAIL load_use_rs1_unused got=%b exp=%b", ctl, C_NONE);
        end
        bus.id_rs2_idx  = 5'd9;
        bus.id_rs2_used = 1'b1;
        bus.id_rs1_idx  = 5'd3;
        #1;
        total++;
        if (ctl !== C_LU) begin
            bad++;
            $display("[TB] FAIL load_use_rs2 got=%b exp=%b", ctl, C_LU);
        end
        bus.ex_w_reg_en = 1'b0;
        #1;
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("[TB] FAIL load_use_no_wen got=%b exp=%b", ctl, C_NONE);
        end
        bus.ex_w_reg_en = 1'b1;
        bus.ex_is_load  = 1'b0;
        #1;
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("[TB] FAIL load_use_not_load got=%b exp=%b", ctl, C_NONE);
        end
        bus.ex_is_load = 1'b1;
        bus.ex_redirect = 1'b1;
        bus.ex_redirect_pc = 64'h8000_0800;
        #1;
        total++;
        if (ctl !== C_REDIR || bus.pc_redirect_target !== 64'h8000_0800) begin
            bad++;
            $display("[TB] FAIL redirect_over_load_use got=%b/%h exp=%b/%h",
                     ctl, bus.pc_redirect_target, C_REDIR, 64'h8000_0800);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_mul();
        bus.ex_mdu_start  = 1'b1;
        bus.ex_mdu_is_div = 1'b0;
        #1;
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("[TB] FAIL mul_start_cycle got=%b exp=%b", ctl, C_NONE);
        end
        tick();
        bus.ex_mdu_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl !== C_BUSY) begin
                bad++;
                $display("[TB] FAIL mul_busy[%0d] got=%b exp=%b", i, ctl, C_BUSY);
            end
            tick();
        end
        total++;
        if (ctl !== C_DONE) begin
            bad++;
            $display("[TB] FAIL mul_done got=%b exp=%b", ctl, C_DONE);
        end
        tick();
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("[TB] FAIL mul_idle_after got=%b exp=%b", ctl, C_NONE);
        end
    endtask

    task automatic test_div_held();
        bus.ex_mdu_start  = 1'b1;
        bus.ex_mdu_is_div = 1'b1;
        #1;
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("[TB] FAIL div_start_cycle got=%b exp=%b", ctl, C_NONE);
        end
        for (int i = 0; i < 33; i++) begin
            tick();
            total++;
            if (ctl !== C_BUSY) begin
                bad++;
                $display("[TB] FAIL div_busy[%0d] got=%b exp=%b", i, ctl, C_BUSY);
            end
        end
        tick();
        total++;
        if (ctl !== C_DONE) begin
            bad++;
            $display("[TB] FAIL div_done got=%b exp=%b", ctl, C_DONE);
        end
        bus.ex_mdu_start = 1'b0;
        tick();
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("[TB] FAIL div_no_restart got=%b exp=%b", ctl, C_NONE);
        end
        clear_inputs();
    endtask

    task automatic test_redirect_pending();
        bus.lsu_busy       = 1'b1;
        bus.ex_redirect    = 1'b1;
        bus.ex_redirect_pc = 64'h8000_0100;
        #1;
        total++;
        if (ctl !== C_LSU) begin
            bad++;
            $display("[TB] FAIL lsu_hold_first got=%b exp=%b", ctl, C_LSU);
        end
        tick();
        bus.ex_redirect    = 1'b0;
        for (int i = 1; i < 4; i++) begin
            // A second branch while frozen must not replace the held target.
            bus.ex_redirect    = (i == 2);
            bus.ex_redirect_pc = 64'h8000_0200;
            #1;
            total++;
            if (ctl !== C_LSU) begin
                bad++;
                $display("[TB] FAIL lsu_hold[%0d] got=%b exp=%b", i, ctl, C_LSU);
            end
            tick();
        end
        bus.lsu_busy    = 1'b0;
        bus.ex_redirect = 1'b0;
        #1;
        total++;
        if (ctl !== C_REDIR || bus.pc_redirect_target !== 64'h8000_0100) begin
            bad++;
            $display("[TB] FAIL pending_release got=%b/%h exp=%b/%h",
                     ctl, bus.pc_redirect_target, C_REDIR, 64'h8000_0100);
        end
        tick();
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("[TB] FAIL pending_cleared got=%b exp=%b", ctl, C_NONE);
        end
    endtask

    task automatic test_trap_priority();
        bus.trap_redirect  = 1'b1;
        bus.trap_pc        = 64'h8000_0400;
        bus.ex_redirect    = 1'b1;
        bus.ex_redirect_pc = 64'h8000_0100;
        #1;
        total++;
        if (ctl !== C_REDIR || bus.pc_redirect_target !== 64'h8000_0400) begin
            bad++;
            $display("[TB] FAIL trap_beats_branch got=%b/%h exp=%b/%h",
                     ctl, bus.pc_redirect_target, C_REDIR, 64'h8000_0400);
        end
        tick();
        clear_inputs();
        bus.lsu_busy       = 1'b1;
        bus.ex_redirect    = 1'b1;
        bus.ex_redirect_pc = 64'h8000_0100;
        tick();
        bus.ex_redirect    = 1'b0;
        bus.trap_redirect  = 1'b1;
        bus.trap_pc        = 64'h8000_0500;
        tick();
        clear_inputs();
        #1;
        total++;
        if (ctl !== C_REDIR || bus.pc_redirect_target !== 64'h8000_0500) begin
            bad++;
            $display("[TB] FAIL trap_overwrites_pending got=%b/%h exp=%b/%h",
                     ctl, bus.pc_redirect_target, C_REDIR, 64'h8000_0500);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.ex_mdu_start = 1'b1;
        tick();
        bus.ex_mdu_start   = 1'b0;
        bus.ex_redirect    = 1'b1;
        bus.ex_redirect_pc = 64'h8000_0a00;
        #1;
        total++;
        if (ctl !== C_BUSY) begin
            bad++;
            $display("[TB] FAIL mdu_freezes_redirect got=%b exp=%b", ctl, C_BUSY);
        end
        tick();
        bus.ex_redirect = 1'b0;
        tick();
        tick();
        total++;
        if (ctl !== C_DONE_REDIR || bus.pc_redirect_target !== 64'h8000_0a00) begin
            bad++;
            $display("[TB] FAIL done_with_redirect got=%b/%h exp=%b/%h",
                     ctl, bus.pc_redirect_target, C_DONE_REDIR, 64'h8000_0a00);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        bus.ex_mdu_start  = 1'b1;
        bus.ex_mdu_is_div = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (ctl !== C_BUSY) begin
            bad++;
            $display("[TB] FAIL div_before_reset got=%b exp=%b", ctl, C_BUSY);
        end
        rst = 1'b0;
        #1;
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("[TB] FAIL reset_mid_div got=%b exp=%b", ctl, C_NONE);
        end
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (ctl !== C_NONE) begin
            bad++;
            $display("[TB] FAIL restart_start_cycle got=%b exp=%b", ctl, C_NONE);
        end
        for (int i = 0; i < 33; i++) begin
            tick();
            total++;
            if (ctl !== C_BUSY) begin
                bad++;
                $display("[TB] FAIL restart_busy[%0d] got=%b exp=%b", i, ctl, C_BUSY);
            end
        end
        bus.ex_mdu_start = 1'b0;
        tick();
        total++;
        if (ctl !== C_DONE) begin
            bad++;
            $display("[TB] FAIL restart_done got=%b exp=%b", ctl, C_DONE);
        end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_load_use();
        test_mul();
        test_div_held();
        test_redirect_pending();
        test_trap_priority();
        test_back_to_back();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
